// File: rtl/vram_port_responder_if.sv
// rtl/vram_port_responder_if.sv - Avalon-MM bus between the VRAM port responder and the memory controller
interface vram_port_responder_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_read;
    logic              mem_waitrequest;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_readdatavalid;

    modport master (
        output mem_address,
        output mem_write,
        output mem_writedata,
        output mem_read,
        input  mem_waitrequest,
        input  mem_readdata,
        input  mem_readdatavalid
    );

    modport slave (
        input  mem_address,
        input  mem_write,
        input  mem_writedata,
        input  mem_read,
        output mem_waitrequest,
        output mem_readdata,
        output mem_readdatavalid
    );
endinterface

// File: rtl/vram_port_responder.sv
// rtl/vram_port_responder.sv - tile-VRAM client port responder: write/read FIFOs drained/filled over Avalon-MM
module vram_port_responder #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int WFIFO_DEPTH = 16,
    parameter int RFIFO_DEPTH = 16,
    parameter int READ_BURST  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_ld,
    input  logic [ADDR_W-1:0]     writeaddr,
    input  logic                  write_req,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  read_ld,
    input  logic [ADDR_W-1:0]     readaddr,
    input  logic                  read_req,
    output logic [DATA_W-1:0]     readdata,
    output logic [15:0]           wr_buffer,
    output logic [15:0]           rd_buffer,
    output logic                  wr_overflow,
    vram_port_responder_if.master mem
);
    localparam int WAW = $clog2(WFIFO_DEPTH);
    localparam int WCW = WAW + 1;
    localparam int RAW = $clog2(RFIFO_DEPTH);
    localparam int RCW = RAW + 1;
    localparam int LW  = $clog2(READ_BURST + 1);

    localparam logic [WCW-1:0]    WF_FULL  = WCW'(WFIFO_DEPTH);
    localparam logic [RCW-1:0]    RF_FULL  = RCW'(RFIFO_DEPTH);
    localparam logic [LW-1:0]     BURST    = LW'(READ_BURST);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [WAW-1:0]    WPTR_ONE = WAW'(1);
    localparam logic [RAW-1:0]    RPTR_ONE = RAW'(1);
    localparam logic [LW-1:0]     LEFT_ONE = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD
    } state_t;

    state_t state_q;
    state_t state_d;

    // write side
    logic [DATA_W-1:0] wf_mem [WFIFO_DEPTH];
    logic [WAW-1:0]    wf_wr_ptr;
    logic [WAW-1:0]    wf_rd_ptr;
    logic [WCW-1:0]    wf_count;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_cmd_stale;
    logic              wf_full;
    logic              wf_push;
    logic              wf_pop;

    // read side
    logic [DATA_W-1:0] rf_mem [RFIFO_DEPTH];
    logic [RAW-1:0]    rf_wr_ptr;
    logic [RAW-1:0]    rf_rd_ptr;
    logic [RCW-1:0]    rf_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [LW-1:0]     rd_left;
    logic [RCW-1:0]    outstanding;
    logic [RCW-1:0]    discard;
    logic              rd_cmd_stale;
    logic              rf_push;
    logic              rf_pop;
    logic              ret_ok;
    logic              ret_drop;
    logic [RCW:0]      rd_commit;
    logic              rd_room;

    // command currently presented on the bus, frozen until accepted
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic wr_accept;
    logic rd_accept;

    assign wr_accept = (state_q == S_WR) && !mem.mem_waitrequest;
    assign rd_accept = (state_q == S_RD) && !mem.mem_waitrequest;

    // The in-flight word stays counted until accepted; a write_ld while it is
    // in flight marks it stale so its acceptance no longer pops the new FIFO.
    assign wf_full = (wf_count == WF_FULL);
    assign wf_push = write_req && (write_ld || !wf_full);
    assign wf_pop  = wr_accept && !wr_cmd_stale && !write_ld;

    // Returns with nothing outstanding are ignored; stale returns are dropped.
    assign ret_ok    = mem.mem_readdatavalid && (outstanding != '0);
    assign ret_drop  = ret_ok && (discard != '0);
    assign rf_push   = ret_ok && (discard == '0) && !read_ld && (rf_count != RF_FULL);
    assign rf_pop    = read_req && (rf_count != '0) && !read_ld;
    assign rd_commit = {1'b0, rf_count} + {1'b0, outstanding};
    assign rd_room   = rd_commit < {1'b0, RF_FULL};

    assign mem.mem_write     = (state_q == S_WR);
    assign mem.mem_read      = (state_q == S_RD);
    assign mem.mem_address   = cmd_addr;
    assign mem.mem_writedata = cmd_wdata;

    assign readdata  = (rf_count != '0) ? rf_mem[rf_rd_ptr] : '0;
    assign wr_buffer = 16'(wf_count);
    assign rd_buffer = 16'(rf_count);

    // Engine state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Engine next state: writes before reads; a reload this cycle defers issue
    // by one cycle so the command is built from the reloaded address.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (write_ld || read_ld) begin
                    state_d = S_IDLE;
                end else if (wf_count != '0) begin
                    state_d = S_WR;
                end else if ((rd_left != '0) && rd_room) begin
                    state_d = S_RD;
                end
            end
            S_WR: begin
                if (!mem.mem_waitrequest) begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (!mem.mem_waitrequest) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latch address/data when a command is launched so reloads cannot alter it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (state_q == S_IDLE) begin
            if (state_d == S_WR) begin
                cmd_addr  <= wr_addr;
                cmd_wdata <= wf_mem[wf_rd_ptr];
            end else if (state_d == S_RD) begin
                cmd_addr <= rd_addr;
            end
        end
    end

    // Write FIFO pointers, count, address and overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wf_wr_ptr    <= '0;
            wf_rd_ptr    <= '0;
            wf_count     <= '0;
            wr_addr      <= '0;
            wr_overflow  <= 1'b0;
            wr_cmd_stale <= 1'b0;
        end else begin
            if (write_ld) begin
                wr_addr   <= writeaddr;
                wf_rd_ptr <= '0;
                wf_wr_ptr <= wf_push ? WPTR_ONE : '0;
                wf_count  <= wf_push ? WCW'(1) : '0;
            end else begin
                if (wf_push) begin
                    wf_wr_ptr <= wf_wr_ptr + WPTR_ONE;
                end
                if (wf_pop) begin
                    wf_rd_ptr <= wf_rd_ptr + WPTR_ONE;
                    wr_addr   <= wr_addr + ADDR_ONE;
                end
                wf_count <= wf_count + WCW'(wf_push) - WCW'(wf_pop);
            end
            if (write_req && !write_ld && wf_full) begin
                wr_overflow <= 1'b1;
            end
            wr_cmd_stale <= (state_q == S_WR) && mem.mem_waitrequest && (write_ld || wr_cmd_stale);
        end
    end

    // Write FIFO storage; a push alongside write_ld lands in the first slot.
    always_ff @(posedge clk) begin
        if (wf_push) begin
            wf_mem[write_ld ? '0 : wf_wr_ptr] <= writedata;
        end
    end

    // Read prefetch bookkeeping and read FIFO pointers/count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_wr_ptr    <= '0;
            rf_rd_ptr    <= '0;
            rf_count     <= '0;
            rd_addr      <= '0;
            rd_left      <= '0;
            outstanding  <= '0;
            discard      <= '0;
            rd_cmd_stale <= 1'b0;
        end else begin
            outstanding <= outstanding + RCW'(rd_accept) - RCW'(ret_ok);
            if (read_ld) begin
                rd_addr   <= readaddr;
                rd_left   <= BURST;
                rf_wr_ptr <= '0;
                rf_rd_ptr <= '0;
                rf_count  <= '0;
                // everything still in flight after this edge belongs to the old request
                discard   <= outstanding + RCW'(rd_accept) - RCW'(ret_ok);
            end else begin
                discard <= discard + RCW'(rd_accept && rd_cmd_stale) - RCW'(ret_drop);
                if (rd_accept && !rd_cmd_stale) begin
                    rd_addr <= rd_addr + ADDR_ONE;
                    rd_left <= rd_left - LEFT_ONE;
                end
                if (rf_push) begin
                    rf_wr_ptr <= rf_wr_ptr + RPTR_ONE;
                end
                if (rf_pop) begin
                    rf_rd_ptr <= rf_rd_ptr + RPTR_ONE;
                end
                rf_count <= rf_count + RCW'(rf_push) - RCW'(rf_pop);
            end
            rd_cmd_stale <= (state_q == S_RD) && mem.mem_waitrequest && (read_ld || rd_cmd_stale);
        end
    end

    // Read FIFO storage.
    always_ff @(posedge clk) begin
        if (rf_push) begin
            rf_mem[rf_wr_ptr] <= mem.mem_readdata;
        end
    end
endmodule
